// File: rtl/stream_minmax.sv
// Streaming packet reducer: accepts unsigned samples over valid/ready and returns
// the packet maximum, minimum and a saturating sample count over valid/ready.
module stream_minmax #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire, out_fire;

  // Handshake qualifiers; ready/valid depend only on state.
  always_comb begin
    in_ready  = (state_q != StHold);
    out_valid = (state_q == StHold);
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
  end

  // Next-state and accumulator update.
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          // First sample seeds both extremes; old results stay visible until now.
          max_d   = in_data;
          min_d   = in_data;
          cnt_d   = CntOne;
          state_d = in_last ? StHold : StAcc;
        end
      end
      StAcc: begin
        if (in_fire) begin
          if (in_data > max_q) max_d = in_data;
          if (in_data < min_q) min_d = in_data;
          if (cnt_q != CntMax) cnt_d = cnt_q + CntOne;
          state_d = in_last ? StHold : StAcc;
        end
      end
      StHold: begin
        if (out_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      max_q   <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result ports are the accumulator registers themselves.
  always_comb begin
    out_max   = max_q;
    out_min   = min_q;
    out_count = cnt_q;
  end

endmodule

// File: tb/tb_stream_minmax.sv
// Directed bench for stream_minmax: default instance plus a CNT_W=2 instance
// for counter saturation.
module tb_stream_minmax;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_max, out_min;
  logic [7:0]  out_count;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [15:0] s_in_data = '0;
  logic        s_in_last = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [15:0] s_out_max, s_out_min;
  logic [1:0]  s_out_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_minmax #(.WIDTH(16), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min),
    .out_count (out_count)
  );

  stream_minmax #(.WIDTH(16), .CNT_W(2)) u_dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_last   (s_in_last),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_max   (s_out_max),
    .out_min   (s_out_min),
    .out_count (s_out_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one sample at a falling edge; returns at the falling edge after transfer.
  task automatic push(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    in_last  = 1'b0;
  endtask

  // Consume the held result and confirm release back to IDLE.
  task automatic take(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_released"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_again"}, 32'(in_ready), 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [15:0] mx, input logic [15:0] mn,
                               input logic [7:0] cnt);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_max"}, 32'(out_max), 32'(mx));
    check({tag, "_min"}, 32'(out_min), 32'(mn));
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
  endtask

  logic [15:0] sat_data [5];

  initial begin
    sat_data[0] = 16'd1; sat_data[1] = 16'd2; sat_data[2] = 16'd3;
    sat_data[3] = 16'd4; sat_data[4] = 16'd0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_max", 32'(out_max), 32'd0);
    check("rst_min", 32'(out_min), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);

    // 1: basic two-sample packet, result the cycle after last
    push(16'd10, 1'b0);
    check("t1_not_early", 32'(out_valid), 32'd0);
    push(16'd20, 1'b1);
    expect_result("t1", 16'd20, 16'd10, 8'd2);
    take("t1");
    check("t1_max_kept", 32'(out_max), 32'd20);

    // 2: descending pair, then ties
    push(16'd40, 1'b0);
    push(16'd30, 1'b1);
    expect_result("t2a", 16'd40, 16'd30, 8'd2);
    take("t2a");
    push(16'd7, 1'b0);
    push(16'd7, 1'b0);
    push(16'd7, 1'b1);
    expect_result("t2b", 16'd7, 16'd7, 8'd3);
    take("t2b");

    // 3: single full-scale sample
    push(16'hFFFF, 1'b1);
    expect_result("t3", 16'hFFFF, 16'hFFFF, 8'd1);
    take("t3");

    // 4: back-pressure in HOLD with a new sample waiting
    push(16'd100, 1'b0);
    push(16'd50, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'd1;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_result("t4_hold", 16'd100, 16'd50, 8'd2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t4_released", 32'(out_valid), 32'd0);
    check("t4_ready_again", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_result("t4_next", 16'd1, 16'd1, 8'd1);
    take("t4_next");

    // 5: reset mid-packet discards partial data
    push(16'd200, 1'b0);
    push(16'd3, 1'b0);
    push(16'd77, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_ready", 32'(in_ready), 32'd1);
    check("t5_rst_max", 32'(out_max), 32'd0);
    @(negedge clk);
    check("t5_no_stale", 32'(out_valid), 32'd0);
    push(16'd5, 1'b0);
    push(16'd9, 1'b1);
    expect_result("t5", 16'd9, 16'd5, 8'd2);
    take("t5");

    // 6: counter saturation on the CNT_W=2 instance
    check("t6_ready", 32'(s_in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = sat_data[i];
      s_in_last  = (i == 4);
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
    check("t6_valid", 32'(s_out_valid), 32'd1);
    check("t6_count", 32'(s_out_count), 32'd3);
    check("t6_max", 32'(s_out_max), 32'd4);
    check("t6_min", 32'(s_out_min), 32'd0);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check("t6_released", 32'(s_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
